uart_byte_rx: RTL and testbench

Serial receiver that sits directly upstream of the on-screen text renderer. It recovers 8N1 bytes from the board's RX pin using 16x oversampling. It delivers each good byte on `data` with a one-cycle `we` strobe, the write-enable/data pair the text renderer consumes. Bytes with framing errors are flagged and never written.

---
 rtl/uart_byte_rx.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_byte_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// uart_byte_rx
// 8N1 serial receiver with 16x oversampling, feeding the on-screen text renderer.
// A byte that passes the stop-bit check is presented on `data` with a one-cycle
// `we` strobe. A byte whose stop bit reads low raises a one-cycle `frame_err`,
// leaves `data` untouched, and parks the FSM in RECOVER until the line idles
// high again, so a held-low break cannot look like a new start bit.

module uart_byte_rx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600,
  parameter int DIV    = CLK_HZ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       we,
  output logic       frame_err,
  output logic       busy
);

  // Width of the oversample divider; DIV >= 2 keeps this at least one bit.
  localparam int TW = $clog2(DIV);
  localparam logic [TW-1:0] TCNT_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] TCNT_ONE  = TW'(1);

  // Oversample slot numbers used for sampling decisions.
  localparam logic [3:0] SCNT_MID  = 4'd7;   // middle of the start bit
  localparam logic [3:0] SCNT_LAST = 4'd15;  // one full bit after the previous sample
  localparam logic [2:0] BCNT_LAST = 3'd7;   // eighth data bit

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  // Synchronizer
  logic rx_meta_r;
  logic rxs_r;

  // FSM
  state_t state_r;
  state_t state_nxt_s;

  // Timing / datapath
  logic [TW-1:0] tcnt_r;
  logic          tick_s;
  logic [3:0]    scnt_r;
  logic [2:0]    bcnt_r;
  logic [7:0]    sh_r;

  // Sampling events decoded from state and counters
  logic start_sample_s;
  logic data_sample_s;
  logic last_bit_s;
  logic stop_sample_s;
  logic counting_s;

  // Output path
  logic       we_nxt_s;
  logic       frame_err_nxt_s;
  logic       busy_s;
  logic [7:0] data_r;
  logic       we_r;
  logic       frame_err_r;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  assign tick_s         = (tcnt_r == TCNT_LAST);
  assign start_sample_s = (state_r == S_START) && tick_s && (scnt_r == SCNT_MID);
  assign data_sample_s  = (state_r == S_DATA)  && tick_s && (scnt_r == SCNT_LAST);
  assign last_bit_s     = data_sample_s && (bcnt_r == BCNT_LAST);
  assign stop_sample_s  = (state_r == S_STOP)  && tick_s && (scnt_r == SCNT_LAST);
  // The divider only runs while a frame is being timed.
  assign counting_s     = (state_r == S_START) || (state_r == S_DATA) || (state_r == S_STOP);

  // Two-flop synchronizer for the asynchronous rx pin; idles high out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rxs_r     <= rx_meta_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!rxs_r) begin
          state_nxt_s = S_START;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_START: begin
        // A line that is high again mid start bit was only a glitch.
        if (start_sample_s) begin
          if (rxs_r) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_DATA;
          end
        end else begin
          state_nxt_s = S_START;
        end
      end
      S_DATA: begin
        if (last_bit_s) begin
          state_nxt_s = S_STOP;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_STOP: begin
        if (stop_sample_s) begin
          if (rxs_r) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_RECOVER;
          end
        end else begin
          state_nxt_s = S_STOP;
        end
      end
      S_RECOVER: begin
        // Hold off until the break ends so it cannot retrigger a frame.
        if (rxs_r) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RECOVER;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // FSM output decode: strobe requests and the busy flag.
  always_comb begin
    we_nxt_s        = 1'b0;
    frame_err_nxt_s = 1'b0;
    busy_s          = 1'b0;
    case (state_r)
      S_IDLE: begin
        busy_s = 1'b0;
      end
      S_START, S_DATA, S_RECOVER: begin
        busy_s = 1'b1;
      end
      S_STOP: begin
        busy_s = 1'b1;
        if (stop_sample_s) begin
          we_nxt_s        = rxs_r;
          frame_err_nxt_s = ~rxs_r;
        end else begin
          we_nxt_s        = 1'b0;
          frame_err_nxt_s = 1'b0;
        end
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Oversample tick divider: counts 0..DIV-1 while timing a frame, held at 0 otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_r <= '0;
    end else if (!counting_s) begin
      tcnt_r <= '0;
    end else if (tick_s) begin
      tcnt_r <= '0;
    end else begin
      tcnt_r <= tcnt_r + TCNT_ONE;
    end
  end

  // Sample-slot counter: restarts at each phase boundary, otherwise advances per tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt_r <= 4'd0;
    end else if (!counting_s) begin
      scnt_r <= 4'd0;
    end else if (start_sample_s || last_bit_s) begin
      scnt_r <= 4'd0;
    end else if (tick_s) begin
      scnt_r <= scnt_r + 4'd1;
    end else begin
      scnt_r <= scnt_r;
    end
  end

  // Data-bit counter: cleared while idle, steps once per data-bit sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt_r <= 3'd0;
    end else if (state_r == S_IDLE) begin
      bcnt_r <= 3'd0;
    end else if (data_sample_s) begin
      bcnt_r <= bcnt_r + 3'd1;
    end else begin
      bcnt_r <= bcnt_r;
    end
  end

  // Shift register: LSB arrives first, so new bits enter at the top and move down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_r <= 8'h00;
    end else if (data_sample_s) begin
      sh_r <= {rxs_r, sh_r[7:1]};
    end else begin
      sh_r <= sh_r;
    end
  end

  // Registered outputs: latch the byte and pulse the matching strobe for one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r      <= 8'h00;
      we_r        <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      we_r        <= we_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      if (we_nxt_s) begin
        data_r <= sh_r;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign data      = data_r;
  assign we        = we_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_s;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Testbench for uart_byte_rx at DIV=10 (160 clocks per bit).
// Expected bytes are queued as frames are sent; a negedge monitor collects
// every `we` byte with its cycle stamp, and each scenario task pops and compares.

module tb_uart_byte_rx;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 10_000;
  localparam int BIT    = 160;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       we;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  int unsigned obs_cyc_q[$];

  int unsigned cyc      = 0;
  int          we_cnt   = 0;
  int          fe_cnt   = 0;
  int          viol_cnt = 0;
  logic        prev_we  = 1'b0;
  logic        prev_fe  = 1'b0;

  uart_byte_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .data(data), .we(we), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: collect strobes, flag overlapping/wide strobes and busy after we.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (we === 1'b1) begin
      obs_q.push_back(data);
      obs_cyc_q.push_back(cyc);
      we_cnt = we_cnt + 1;
    end
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    if (we === 1'b1 && frame_err === 1'b1) viol_cnt = viol_cnt + 1;
    if (prev_we && (we !== 1'b0 || busy !== 1'b0)) viol_cnt = viol_cnt + 1;
    if (prev_fe && frame_err !== 1'b0) viol_cnt = viol_cnt + 1;
    prev_we = (we === 1'b1);
    prev_fe = (frame_err === 1'b1);
  end

  // Drive one 8N1 frame; caller is aligned to a negedge, returns on a negedge.
  task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop);
    rx = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (cpb) @(negedge clk);
    end
    rx = stop;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h want 00", data); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", we); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int w0 = we_cnt; int f0 = fe_cnt; int v0 = viol_cnt;
    int unsigned c0; int unsigned c1; logic [7:0] e; logic [7:0] o;
    exp_q.push_back(8'h41);
    c0 = cyc;
    send_byte(8'h41, BIT, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (we_cnt - w0 != 1) begin bad++; $display("FAIL single_we_count: got %0d want 1", we_cnt - w0); end
    total++; if (fe_cnt != f0) begin bad++; $display("FAIL single_ferr: got %0d want 0", fe_cnt - f0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL single_sb: got none want %02h", e); end
      else begin
        o = obs_q.pop_front(); c1 = obs_cyc_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL single_sb: got %02h want %02h", o, e); end
        total++;
        if (c1 - c0 < 1518 || c1 - c0 > 1528) begin bad++; $display("FAIL single_latency: got %0d want ~1523", c1 - c0); end
      end
    end
    total++; if (data !== 8'h41) begin bad++; $display("FAIL single_data_hold: got %02h want 41", data); end
    total++; if (viol_cnt != v0) begin bad++; $display("FAIL single_strobe_rules: got %0d want 0", viol_cnt - v0); end
  endtask

  task automatic test_back_to_back();
    int w0 = we_cnt; int f0 = fe_cnt;
    int unsigned cs[2]; logic [7:0] e; logic [7:0] o;
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h3E);
    send_byte(8'h0D, BIT, 1'b1);
    send_byte(8'h3E, BIT, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (we_cnt - w0 != 2) begin bad++; $display("FAIL b2b_we_count: got %0d want 2", we_cnt - w0); end
    total++; if (fe_cnt != f0) begin bad++; $display("FAIL b2b_ferr: got %0d want 0", fe_cnt - f0); end
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      cs[k] = 0;
      total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL b2b_sb: got none want %02h", e); end
      else begin
        o = obs_q.pop_front(); cs[k] = obs_cyc_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL b2b_sb: got %02h want %02h", o, e); end
      end
    end
    total++;
    if (cs[1] - cs[0] < 1598 || cs[1] - cs[0] > 1602) begin
      bad++; $display("FAIL b2b_spacing: got %0d want 1600", cs[1] - cs[0]);
    end
  endtask

  task automatic test_glitch();
    int w0 = we_cnt; int f0 = fe_cnt;
    logic [7:0] e; logic [7:0] o;
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    total++; if (we_cnt != w0) begin bad++; $display("FAIL glitch_we: got %0d want 0", we_cnt - w0); end
    total++; if (fe_cnt != f0) begin bad++; $display("FAIL glitch_ferr: got %0d want 0", fe_cnt - f0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle: busy got %b want 0", busy); end
    exp_q.push_back(8'h55);
    send_byte(8'h55, BIT, 1'b1);
    repeat (20) @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (obs_q.size() == 0) begin bad++; $display("FAIL glitch_after_sb: got none want %02h", e); end
    else begin
      o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
      if (o !== e) begin bad++; $display("FAIL glitch_after_sb: got %02h want %02h", o, e); end
    end
  endtask

  task automatic test_frame_err();
    int w0 = we_cnt; int f0 = fe_cnt;
    logic [7:0] e; logic [7:0] o;
    send_byte(8'hA5, BIT, 1'b0);
    repeat (1500) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy: got %b want 1", busy); end
    repeat (1500) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy_late: got %b want 1", busy); end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_release: busy got %b want 0", busy); end
    total++; if (fe_cnt - f0 != 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", fe_cnt - f0); end
    total++; if (we_cnt != w0) begin bad++; $display("FAIL ferr_no_we: got %0d want 0", we_cnt - w0); end
    total++; if (data !== 8'h55) begin bad++; $display("FAIL ferr_data_kept: got %02h want 55", data); end
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, BIT, 1'b1);
    repeat (20) @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (obs_q.size() == 0) begin bad++; $display("FAIL ferr_after_sb: got none want %02h", e); end
    else begin
      o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
      if (o !== e) begin bad++; $display("FAIL ferr_after_sb: got %02h want %02h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    int w0; int f0;
    logic [7:0] e; logic [7:0] o;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;                       // 0xFF: every data bit high
    repeat (3 * BIT + BIT / 2) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    reset = 1'b0;
    #1;
    total++; if (data !== 8'h00) begin bad++; $display("FAIL midrst_data: got %02h want 00", data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (we !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL midrst_strobes: got %b%b want 00", we, frame_err); end
    repeat (20) @(negedge clk);
    w0 = we_cnt; f0 = fe_cnt;
    reset = 1'b1;
    repeat (2000) @(negedge clk);
    total++; if (we_cnt != w0 || fe_cnt != f0) begin bad++; $display("FAIL midrst_no_strobe: got %0d/%0d want 0/0", we_cnt - w0, fe_cnt - f0); end
    exp_q.push_back(8'h30);
    send_byte(8'h30, BIT, 1'b1);
    repeat (20) @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (obs_q.size() == 0) begin bad++; $display("FAIL midrst_after_sb: got none want %02h", e); end
    else begin
      o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
      if (o !== e) begin bad++; $display("FAIL midrst_after_sb: got %02h want %02h", o, e); end
    end
  endtask

  task automatic test_baud_skew();
    int rates[2] = '{157, 163};
    logic [7:0] e; logic [7:0] o;
    for (int r = 0; r < 2; r++) begin
      int w0 = we_cnt; int f0 = fe_cnt;
      exp_q.push_back(8'hC3);
      send_byte(8'hC3, rates[r], 1'b1);
      repeat (40) @(negedge clk);
      total++; if (we_cnt - w0 != 1 || fe_cnt != f0) begin bad++; $display("FAIL skew_%0d_strobes: got we=%0d ferr=%0d want 1/0", rates[r], we_cnt - w0, fe_cnt - f0); end
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL skew_%0d_sb: got none want %02h", rates[r], e); end
      else begin
        o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
        if (o !== e) begin bad++; $display("FAIL skew_%0d_sb: got %02h want %02h", rates[r], o, e); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_baud_skew();
    total++;
    if (obs_q.size() != 0 || viol_cnt != 0) begin
      bad++; $display("FAIL final_clean: got extra=%0d strobe_violations=%0d want 0/0", obs_q.size(), viol_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
